// File: rtl/mult_eval_pkg.sv
// Shared types, default widths and helpers for the multiplier error analyzer.
// Latency: n/a (types and combinational helper only).
// Backpressure: n/a.
package mult_eval_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    REPORT = 2'd3
  } err_state_t;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CNT_W = 24;
  localparam int DEF_SUM_W = 40;

  // Widest product the helper handles; callers zero-extend into it and
  // size-cast the result back down to their own product width.
  localparam int ABS_W = 64;

  function automatic logic [ABS_W-1:0] abs_diff(input logic [ABS_W-1:0] a,
                                                input logic [ABS_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/err_dist_stage.sv
// Stage 1 of the analyzer: registers |exact - approx|, the match flag and last.
// Latency: 1 cycle from an accepted pair to s1_valid.
// Backpressure: none; it captures every fire and the top gates fire via in_ready.
module err_dist_stage
  import mult_eval_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             fire,
  input  logic [WIDTH-1:0] exact,
  input  logic [WIDTH-1:0] approx,
  input  logic             last,
  output logic             s1_valid,
  output logic [WIDTH-1:0] s1_ed,
  output logic             s1_eq,
  output logic             s1_last
);

  // Capture the error distance of each accepted pair; clear drops the in-flight pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_ed    <= '0;
      s1_eq    <= 1'b0;
      s1_last  <= 1'b0;
    end else if (clear) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
    end else begin
      s1_valid <= fire;
      if (fire) begin
        s1_ed   <= WIDTH'(abs_diff(ABS_W'(exact), ABS_W'(approx)));
        s1_eq   <= (exact == approx);
        s1_last <= last;
      end
    end
  end

endmodule

// File: rtl/mult_err_analyzer.sv
// Accumulates error statistics over a stream of (exact, approx) product pairs.
// Latency: pair visible in stats 2 cycles after acceptance; res_valid 3 cycles after last.
// Backpressure: in_ready drops from last acceptance until the result is taken by res_ready.
module mult_err_analyzer
  import mult_eval_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W,
  parameter int SUM_W = DEF_SUM_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_exact,
  input  logic [WIDTH-1:0] in_approx,
  input  logic             in_last,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] n_total,
  output logic [CNT_W-1:0] n_correct,
  output logic [CNT_W-1:0] n_wrong,
  output logic [WIDTH-1:0] max_ed,
  output logic [SUM_W-1:0] sum_ed,
  output logic             sat
);

  err_state_t       state, state_nx;
  logic             fire;
  logic             start_run;
  logic             s1_valid;
  logic [WIDTH-1:0] s1_ed;
  logic             s1_eq;
  logic             s1_last;
  logic [SUM_W:0]   sum_wide;

  assign in_ready  = (state == IDLE) || (state == RUN);
  assign res_valid = (state == REPORT);
  // clear wins over a simultaneous handshake: the pair is dropped.
  assign fire      = in_valid && in_ready && !clear;
  // Stats of the previous run stay readable until the next run really starts.
  assign start_run = fire && (state == IDLE);
  // One spare bit to detect the accumulator running past all-ones.
  assign sum_wide  = {1'b0, sum_ed} + (SUM_W + 1)'(s1_ed);

  err_dist_stage #(.WIDTH(WIDTH)) u_stage (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .fire     (fire),
    .exact    (in_exact),
    .approx   (in_approx),
    .last     (in_last),
    .s1_valid (s1_valid),
    .s1_ed    (s1_ed),
    .s1_eq    (s1_eq),
    .s1_last  (s1_last)
  );

  // Run-control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state: run opens on first pair, drains after last, reports until taken.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (fire) state_nx = in_last ? DRAIN : RUN;
      RUN:     if (fire && in_last) state_nx = DRAIN;
      // In DRAIN stage 1 can only hold the last pair; once it has moved into
      // the accumulators the statistics are final.
      DRAIN:   if (!(s1_valid && s1_last)) state_nx = REPORT;
      REPORT:  if (res_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (clear) state_nx = IDLE;
  end

  // Stage 2: saturating accumulation of counts, max and sum of error distance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_total   <= '0;
      n_correct <= '0;
      n_wrong   <= '0;
      max_ed    <= '0;
      sum_ed    <= '0;
      sat       <= 1'b0;
    end else if (clear || start_run) begin
      n_total   <= '0;
      n_correct <= '0;
      n_wrong   <= '0;
      max_ed    <= '0;
      sum_ed    <= '0;
      sat       <= 1'b0;
    end else if (s1_valid) begin
      if (&n_total) sat <= 1'b1;
      else          n_total <= n_total + CNT_W'(1);

      if (s1_eq) begin
        if (&n_correct) sat <= 1'b1;
        else            n_correct <= n_correct + CNT_W'(1);
      end else begin
        if (&n_wrong) sat <= 1'b1;
        else          n_wrong <= n_wrong + CNT_W'(1);
      end

      if (s1_ed > max_ed) max_ed <= s1_ed;

      if (sum_wide[SUM_W]) begin
        sum_ed <= '1;
        sat    <= 1'b1;
      end else begin
        sum_ed <= sum_wide[SUM_W-1:0];
      end
    end
  end

endmodule

// File: doc/mult_err_analyzer.md
Name: mult_err_analyzer

Overview:
- Hardware response analyzer for approximate-multiplier characterization. It consumes a stream of (exact product, approximate product) pairs and accumulates error statistics: total, correct and wrong counts, maximum error distance and summed error distance.
- It is the consuming end of the pair stream our exhaustive sweep benches write out, so on-chip or FPGA sweeps need no file dump.
- Sits downstream of the operand sweeper and the multiplier under test; results go to a CSR or host reader.

Parameters:
- WIDTH, 16, bit width of each product (16 for the 8x8 sweep, 32 for 16x16).
- CNT_W, 24, width of the sample counters.
- SUM_W, 40, width of the error-distance accumulator.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- clear  in  1  synchronous clear of all statistics; returns FSM to IDLE.
- in_valid  in  1  pair valid.
- in_ready  out  1  analyzer can accept a pair.
- in_exact  in  WIDTH  exact product.
- in_approx  in  WIDTH  approximate product.
- in_last  in  1  marks the final pair of a run.
- res_valid  out  1  result fields valid.
- res_ready  in  1  host accepts the result.
- n_total  out  CNT_W  pairs accepted.
- n_correct  out  CNT_W  pairs with exact == approx.
- n_wrong  out  CNT_W  pairs with exact != approx.
- max_ed  out  WIDTH  maximum |exact - approx|.
- sum_ed  out  SUM_W  sum of |exact - approx|.
- sat  out  1  sticky flag: some counter or the sum saturated.

Behaviour:
- Reset (async assert, sync release): FSM = IDLE, all counters, max_ed, sum_ed and sat = 0, res_valid = 0, in_ready = 1.
- FSM states: IDLE, RUN, DRAIN, REPORT.
  - IDLE -> RUN on the first accepted pair.
  - RUN -> DRAIN when a pair with in_last=1 is accepted.
  - DRAIN -> REPORT once the pipeline is empty.
  - REPORT -> IDLE on res_valid && res_ready. Statistics are held through this transition and are zeroed when the next run's first pair is accepted.
- Handshake:
  - A pair is accepted when in_valid && in_ready.
  - in_ready = 1 in IDLE and RUN, 0 in DRAIN and REPORT.
  - in_exact, in_approx and in_last are sampled only on acceptance.
- Pipeline stage 1 (register): ED = exact >= approx ? exact - approx : approx - exact, computed unsigned at WIDTH bits. The match flag eq is also registered.
- Pipeline stage 2 (accumulate):
  - n_total += 1.
  - n_correct += eq; n_wrong += !eq.
  - max_ed = max(max_ed, ED).
  - sum_ed += ED, zero-extended to SUM_W.
- Latency: an accepted pair is reflected in the outputs 2 cycles after acceptance. When last is accepted in cycle t, res_valid rises in cycle t+3.
- Saturation: any counter or the sum at all-ones holds its value and sets sat. sat clears only on reset, clear, or the start of a new run.
- Outputs are readable at any time; values are final only while res_valid = 1.
- res_valid is held, with fields stable, until res_ready is seen.
- clear has priority over every other event, including a simultaneous acceptance or result handshake. clear asserted mid-run discards in-flight pairs.
- A pair accepted together with in_last in IDLE is a valid one-sample run.
- in_valid asserted in DRAIN or REPORT is ignored and not accepted.
- Invariant: n_correct + n_wrong == n_total unless sat = 1.

Decomposition:
- Package mult_eval_pkg:
  - typedef err_state_t {IDLE, RUN, DRAIN, REPORT}.
  - Default width constants.
  - function abs_diff().
- Sub-module err_dist_stage: stage-1 register holding the |diff|, eq and last pipeline registers with a valid bit.
- The top level holds the FSM, accumulators and result handshake.

Test Plan:
- Single pair, exact=100, approx=100, last=1 -> n_total=1, n_correct=1, n_wrong=0, max_ed=0, sum_ed=0; res_valid rises 3 cycles after acceptance.
- Pairs (10,7), (7,10), (5,5), last on the third -> n_wrong=2, n_correct=1, max_ed=3, sum_ed=6.
- Full 8x8 sweep with an exact model (approx = exact), 65536 pairs -> n_total=65536, n_wrong=0, sum_ed=0.
- Backpressure:
  - res_ready held low for 20 cycles -> res_valid and all fields stable; in_ready=0 throughout.
  - in_valid asserted during REPORT is not accepted.
- clear asserted mid-run after 5 pairs with 2 pairs in flight -> all stats 0 next cycle, FSM in IDLE, no res_valid.
- Saturation: CNT_W=4, 20 pairs -> n_total=15, sat=1; async rst_n pulse mid-run -> outputs 0 immediately, without waiting for a clock edge.
